// File: rtl/audio_mixer_playout.sv
// Sample ROM for the playout mixer plus a multi-voice mixer that walks active
// voices once per audio frame and emits a saturated signed mix.
package sound_pkg;
  localparam int unsigned SOUND_IDX_W       = 8;
  localparam int unsigned SOUND_ADDR_BITS   = 8;
  localparam int unsigned SOUND_SAMPLE_BITS = 12;

  // [idx][0] = start address, [idx][1] = length in samples (0 = no sound)
  localparam logic [SOUND_ADDR_BITS-1:0] Sound_Start_Length [2**SOUND_IDX_W][2] = '{
    0:  '{8'd0, 8'd3},
    1:  '{8'd3, 8'd1},
    2:  '{8'd3, 8'd1},
    3:  '{8'd3, 8'd1},
    4:  '{8'd3, 8'd1},
    5:  '{8'd4, 8'd1},
    6:  '{8'd4, 8'd1},
    7:  '{8'd4, 8'd1},
    8:  '{8'd4, 8'd1},
    9:  '{8'd5, 8'd1},
    10: '{8'd0, 8'd0},
    default: '{8'd0, 8'd0}
  };

  localparam logic signed [SOUND_SAMPLE_BITS-1:0] Sound [2**SOUND_ADDR_BITS] = '{
    0: 12'sd100,
    1: 12'sd200,
    2: -12'sd50,
    3: 12'sd2047,
    4: 12'h800,
    5: 12'sd1000,
    default: 12'sd0
  };
endpackage

module audio_mixer_playout #(
  parameter int unsigned AUD_BITS       = 12,
  parameter int unsigned SOUND_IDX_BITS = 8,
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned VOL_BITS       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       aud_valid,
  input  logic                       play_sound,
  input  logic                       stop_sound,
  input  logic [SOUND_IDX_BITS-1:0]  sound_idx,
  input  logic                       loop,
  input  logic [VOL_BITS-1:0]        volume,
  output logic signed [AUD_BITS-1:0] audio,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic                       drop,
  output logic                       overrun
);
  import sound_pkg::*;

  localparam int unsigned ADDR_W = SOUND_ADDR_BITS;
  localparam int unsigned VCNT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned ACC_W  = AUD_BITS + $clog2(NUM_VOICES) + 1;
  localparam int unsigned PROD_W = AUD_BITS + VOL_BITS + 2;
  localparam int unsigned GAIN_W = VOL_BITS + 2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (AUD_BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (AUD_BITS - 1)));

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

  state_t state;
  logic [VCNT_W-1:0] vcnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [AUD_BITS-1:0] rd_sample;
  logic [VOL_BITS-1:0] rd_vol;

  logic [NUM_VOICES-1:0]     v_active;
  logic [NUM_VOICES-1:0]     v_loop;
  logic [VOL_BITS-1:0]       v_vol   [NUM_VOICES];
  logic [SOUND_IDX_BITS-1:0] v_idx   [NUM_VOICES];
  logic [ADDR_W-1:0]         v_start [NUM_VOICES];
  logic [ADDR_W-1:0]         v_end   [NUM_VOICES];
  logic [ADDR_W-1:0]         v_addr  [NUM_VOICES];

  logic [ADDR_W-1:0] req_start;
  logic [ADDR_W-1:0] req_len;
  logic              play_ok;
  logic              hit;
  logic              free;
  logic [VCNT_W-1:0] hit_sel;
  logic [VCNT_W-1:0] free_sel;
  logic [VCNT_W-1:0] alloc_sel;

  logic signed [SOUND_SAMPLE_BITS-1:0] rom_word;
  logic [GAIN_W-1:0]         gain_u;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W-1:0]  prod_sh;
  logic signed [ACC_W-1:0]   scaled;
  logic signed [ACC_W-1:0]   mix_sum;
  logic signed [AUD_BITS-1:0] mix_sat;

  assign voice_active = v_active;

  assign req_start = Sound_Start_Length[SOUND_IDX_W'(sound_idx)][0];
  assign req_len   = Sound_Start_Length[SOUND_IDX_W'(sound_idx)][1];
  assign play_ok   = play_sound && !stop_sound && (req_len != '0);
  assign alloc_sel = hit ? hit_sel : free_sel;

  // Lowest-index voice already playing this sound, and lowest-index idle voice
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_sel  = '0;
    free_sel = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (v_active[i] && (v_idx[i] == sound_idx)) begin
        hit     = 1'b1;
        hit_sel = VCNT_W'(i);
      end
      if (!v_active[i]) begin
        free     = 1'b1;
        free_sel = VCNT_W'(i);
      end
    end
  end

  // Gain stage on the registered ROM word: (sample * (vol + 1)) >>> VOL_BITS
  always_comb begin
    rom_word = Sound[v_addr[vcnt]];
    gain_u   = {2'b00, rd_vol} + GAIN_W'(1);
    prod     = PROD_W'(rd_sample) * PROD_W'($signed(gain_u));
    prod_sh  = prod >>> VOL_BITS;
    scaled   = ACC_W'(prod_sh);
    mix_sum  = acc + scaled;
    if (mix_sum > SAT_MAX)      mix_sat = AUD_BITS'(SAT_MAX);
    else if (mix_sum < SAT_MIN) mix_sat = AUD_BITS'(SAT_MIN);
    else                        mix_sat = AUD_BITS'(mix_sum);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      vcnt      <= '0;
      acc       <= '0;
      rd_sample <= '0;
      rd_vol    <= '0;
      audio     <= '0;
      drop      <= 1'b0;
      overrun   <= 1'b0;
      v_active  <= '0;
      v_loop    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        v_vol[i]   <= '0;
        v_idx[i]   <= '0;
        v_start[i] <= '0;
        v_end[i]   <= '0;
        v_addr[i]  <= '0;
      end
    end else begin
      drop    <= play_ok && !hit && !free;
      overrun <= aud_valid && (state != IDLE);

      case (state)
        IDLE: begin
          if (aud_valid) begin
            state     <= READ;
            vcnt      <= '0;
            acc       <= '0;
            rd_sample <= '0;
          end
        end
        READ: begin
          rd_sample <= v_active[vcnt] ? AUD_BITS'(rom_word) : '0;
          rd_vol    <= v_vol[vcnt];
          acc       <= mix_sum;
          if (v_active[vcnt]) begin
            if (v_addr[vcnt] == v_end[vcnt]) begin
              if (v_loop[vcnt]) v_addr[vcnt] <= v_start[vcnt];
              else              v_active[vcnt] <= 1'b0;
            end else begin
              v_addr[vcnt] <= v_addr[vcnt] + ADDR_W'(1);
            end
          end
          if (vcnt == VCNT_W'(NUM_VOICES - 1)) state <= DRAIN;
          else                                 vcnt  <= vcnt + VCNT_W'(1);
        end
        DRAIN: begin
          audio <= mix_sat;
          state <= OUT;
        end
        default: state <= IDLE;
      endcase

      // Requests come after the scan update so they override it
      if (stop_sound) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (v_idx[i] == sound_idx) v_active[i] <= 1'b0;
        end
      end else if (play_ok && (hit || free)) begin
        v_active[alloc_sel] <= 1'b1;
        v_loop[alloc_sel]   <= loop;
        v_vol[alloc_sel]    <= volume;
        v_idx[alloc_sel]    <= sound_idx;
        v_start[alloc_sel]  <= req_start;
        v_end[alloc_sel]    <= req_start + req_len - ADDR_W'(1);
        v_addr[alloc_sel]   <= req_start;
      end
    end
  end
endmodule

// File: doc/audio_mixer_playout.md
AUDIO_MIXER_PLAYOUT -- requirements
Module: audio_mixer_playout

Interface
REQ-001 SHALL have parameter AUD_BITS, default 12, signed two's-complement sample/output width.
REQ-002 SHALL have parameter SOUND_IDX_BITS, default 8, sound index width into sound_pkg tables.
REQ-003 SHALL have parameter NUM_VOICES, default 4, number of concurrent playback voices (1..16).
REQ-004 SHALL have parameter VOL_BITS, default 4, per-voice volume width.
REQ-005 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-006 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port aud_valid  in  1  sample-rate pulse, one clk wide.
REQ-008 SHALL have port play_sound  in  1  one-cycle start request.
REQ-009 SHALL have port stop_sound  in  1  one-cycle stop request.
REQ-010 SHALL have port sound_idx  in  SOUND_IDX_BITS  sound for play/stop request.
REQ-011 SHALL have port loop  in  1  loop mode, captured with play_sound.
REQ-012 SHALL have port volume  in  VOL_BITS  gain, captured with play_sound.
REQ-013 SHALL have port audio  out  AUD_BITS  mixed, saturated signed output.
REQ-014 SHALL have port voice_active  out  NUM_VOICES  per-voice playing flags.
REQ-015 SHALL have port drop  out  1  one-cycle pulse: play request rejected, no free voice.
REQ-016 SHALL have port overrun  out  1  one-cycle pulse: aud_valid arrived while mix busy.

Function
REQ-017 SHALL take sound start address and length from sound_pkg::Sound_Start_Length[idx][0]/[1] and samples from sound_pkg::Sound; a sound plays addresses start..start+length-1 exactly once per pass.
REQ-018 SHALL per voice hold: active, loop, volume, idx, start, end, current address.
REQ-019 On play_sound: if a voice already plays the same idx, that voice restarts at start with new loop/volume; else lowest-index idle voice is allocated; if none idle, request discarded and drop pulses next cycle.
REQ-020 SHALL ignore play_sound for length-0 sounds (no allocation, no drop).
REQ-021 On stop_sound: all voices with matching idx go idle next cycle; stop_sound and play_sound same cycle: stop wins, play ignored.
REQ-022 Mix FSM states: IDLE, READ, DRAIN, OUT; IDLE->READ on aud_valid.
REQ-023 READ: voice counter 0..NUM_VOICES-1, one registered ROM read per cycle; active voice address advances by 1 when read issued; idle voices contribute 0.
REQ-024 At end address: loop=1 wraps to start; loop=0 voice goes idle after last sample is read.
REQ-025 DRAIN: one cycle for final ROM data; OUT: audio updated; then IDLE.
REQ-026 audio SHALL update exactly NUM_VOICES+2 cycles after the aud_valid cycle.
REQ-027 Scaled sample = (sample * (volume+1)) >>> VOL_BITS, arithmetic; volume all-ones = unity.
REQ-028 Accumulator width AUD_BITS+clog2(NUM_VOICES)+1; result saturated to [-2^(AUD_BITS-1), 2^(AUD_BITS-1)-1].
REQ-029 aud_valid outside IDLE SHALL be ignored and pulse overrun next cycle; current mix unaffected.
REQ-030 play/stop during READ SHALL apply immediately; a voice allocated mid-scan contributes only if its slot not yet read.
REQ-031 All voices idle SHALL produce audio=0 at next OUT.
REQ-032 voice_active[i] SHALL equal voice i active bit, registered.

Reset
REQ-033 reset_n low SHALL asynchronously clear all voices, FSM to IDLE, audio=0, voice_active=0, drop=0, overrun=0.
REQ-034 Reset mid-mix SHALL abort the mix; no audio update until next aud_valid after reset release.

Verification
REQ-035 Sound len 3 samples {100,200,-50}, vol=15, loop=0, aud_valid every 20 clk -> audio 100,200,-50,0; voice_active[0] clears after third read.
REQ-036 Same sound loop=1 -> audio repeats 100,200,-50,100...; stop_sound idx -> voice idle, audio 0 next frame.
REQ-037 Four voices each sample 2047 (AUD_BITS=12), vol=15 -> audio=2047 saturated; all -2048 -> -2048.
REQ-038 Fifth play with 4 voices busy -> drop pulse 1 cycle, voice_active stays 4'b1111; vol=7 on 1000 -> 500.
REQ-039 aud_valid at T, again at T+2 -> overrun pulse at T+3, audio updates once at T+NUM_VOICES+2.
REQ-040 reset_n low during READ -> audio=0, voice_active=0 immediately, no stray update after release.
